// File: rtl/sos_detect_module_pkg.sv
// Shared types and constants for the SOS Morse receiver: FSM states, symbol codes,
// expected S-O-S pattern and default timing (common with the generator side).
package sos_detect_module_pkg;

    localparam int unsigned DUR_W = 10;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned N_SYM = 9;

    // One bit per symbol, 1 = dash, bit 0 = first symbol received
    localparam logic [N_SYM-1:0] SOS_PATTERN = 9'b000_111_000;

    localparam int unsigned DEF_T_MS        = 50000;
    localparam int unsigned DEF_DOT_MIN_MS  = 50;
    localparam int unsigned DEF_DOT_MAX_MS  = 150;
    localparam int unsigned DEF_DASH_MIN_MS = 250;
    localparam int unsigned DEF_DASH_MAX_MS = 500;
    localparam int unsigned DEF_GAP_MIN_MS  = 50;
    localparam int unsigned DEF_GAP_MAX_MS  = 600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HIGH,
        ST_MEAS_HIGH,
        ST_MEAS_LOW,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SYM_DOT,
        SYM_DASH,
        SYM_BAD
    } sym_e;

    function automatic sym_e classify_pulse(input logic [DUR_W-1:0] dur,
                                            input logic [DUR_W-1:0] dot_min,
                                            input logic [DUR_W-1:0] dot_max,
                                            input logic [DUR_W-1:0] dash_min,
                                            input logic [DUR_W-1:0] dash_max);
        if (dur >= dot_min && dur <= dot_max) return SYM_DOT;
        if (dur >= dash_min && dur <= dash_max) return SYM_DASH;
        return SYM_BAD;
    endfunction

endpackage

// File: rtl/sos_detect_module_if.sv
// Control handshake and Morse line bundle between a controller and the SOS receiver.
interface sos_detect_module_if;
    import sos_detect_module_pkg::*;

    logic             Start_Sig;
    logic             Pin_In;
    logic             Done_Sig;
    logic             Match_Sig;
    logic [CNT_W-1:0] Sym_Cnt;

    modport master (output Start_Sig, output Pin_In,
                    input  Done_Sig, input Match_Sig, input Sym_Cnt);

    modport slave  (input  Start_Sig, input Pin_In,
                    output Done_Sig, output Match_Sig, output Sym_Cnt);
endinterface

// File: rtl/sos_detect_module_pulse_meter.sv
// Synchronises the Morse pin, flags its edges and measures the time since the last
// edge in whole milliseconds (saturating).
module sos_detect_module_pulse_meter
    import sos_detect_module_pkg::*;
#(
    parameter int unsigned T_MS = DEF_T_MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_i,
    output logic             rise_c_o,
    output logic             fall_c_o,
    output logic [DUR_W-1:0] dur_ms_o
);

    localparam int unsigned PRE_W = (T_MS > 1) ? $clog2(T_MS) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    logic             s1_q, s2_q, s3_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             edge_c, tick_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            pre_q <= '0;
            dur_q <= '0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            pre_q <= pre_d;
            dur_q <= dur_d;
        end
    end

    assign rise_c_o = s2_q & ~s3_q;
    assign fall_c_o = ~s2_q & s3_q;
    assign edge_c   = rise_c_o | fall_c_o;
    assign tick_c   = (pre_q == PRE_W'(T_MS - 1));

    // An edge restarts both the prescaler and the duration, swallowing a coincident tick
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        dur_d = dur_q;
        if (edge_c) begin
            pre_d = '0;
            dur_d = '0;
        end else if (tick_c) begin
            pre_d = '0;
            if (dur_q != DUR_MAX) dur_d = dur_q + DUR_W'(1);
        end
    end

    assign dur_ms_o = dur_q;

endmodule

// File: rtl/sos_detect_module.sv
// SOS Morse receiver: classifies each tone pulse as dot/dash and checks the nine-symbol
// S-O-S sequence and its gap timing under a Start_Sig/Done_Sig level handshake.
module sos_detect_module
    import sos_detect_module_pkg::*;
#(
    parameter int unsigned T_MS        = DEF_T_MS,
    parameter int unsigned DOT_MIN_MS  = DEF_DOT_MIN_MS,
    parameter int unsigned DOT_MAX_MS  = DEF_DOT_MAX_MS,
    parameter int unsigned DASH_MIN_MS = DEF_DASH_MIN_MS,
    parameter int unsigned DASH_MAX_MS = DEF_DASH_MAX_MS,
    parameter int unsigned GAP_MIN_MS  = DEF_GAP_MIN_MS,
    parameter int unsigned GAP_MAX_MS  = DEF_GAP_MAX_MS
) (
    input  logic CLK,
    input  logic RSTn,
    sos_detect_module_if.slave bus
);

    localparam logic [DUR_W-1:0] DOT_MIN  = DUR_W'(DOT_MIN_MS);
    localparam logic [DUR_W-1:0] DOT_MAX  = DUR_W'(DOT_MAX_MS);
    localparam logic [DUR_W-1:0] DASH_MIN = DUR_W'(DASH_MIN_MS);
    localparam logic [DUR_W-1:0] DASH_MAX = DUR_W'(DASH_MAX_MS);
    localparam logic [DUR_W-1:0] GAP_MIN  = DUR_W'(GAP_MIN_MS);
    localparam logic [DUR_W-1:0] GAP_MAX  = DUR_W'(GAP_MAX_MS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SYM - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic             match_q, match_d;
    logic             done_q, done_d;

    logic             rise_c, fall_c;
    logic [DUR_W-1:0] dur_ms;
    sym_e             sym_c;
    logic             sym_ok_c;

    sos_detect_module_pulse_meter #(.T_MS(T_MS)) u_meter (
        .clk      (CLK),
        .rst_n    (RSTn),
        .pin_i    (bus.Pin_In),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c),
        .dur_ms_o (dur_ms)
    );

    assign sym_c    = classify_pulse(dur_ms, DOT_MIN, DOT_MAX, DASH_MIN, DASH_MAX);
    assign sym_ok_c = SOS_PATTERN[sym_cnt_q] ? (sym_c == SYM_DASH) : (sym_c == SYM_DOT);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            match_q   <= match_d;
            done_q    <= done_d;
        end
    end

    // Losing Start_Sig while measuring aborts silently; a fall outranks the high timeout
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        match_d   = match_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start_Sig) begin
                    state_d   = ST_WAIT_HIGH;
                    sym_cnt_d = '0;
                    match_d   = 1'b0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!bus.Start_Sig) begin
                    state_d = ST_IDLE;
                    match_d = 1'b0;
                end else if (rise_c) begin
                    state_d = ST_MEAS_HIGH;
                end
            end
            ST_MEAS_HIGH: begin
                if (!bus.Start_Sig) begin
                    state_d = ST_IDLE;
                    match_d = 1'b0;
                end else if (fall_c) begin
                    if (!sym_ok_c) begin
                        state_d = ST_DONE;
                        match_d = 1'b0;
                    end else if (sym_cnt_q == LAST_IDX) begin
                        state_d   = ST_DONE;
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        match_d   = 1'b1;
                    end else begin
                        state_d   = ST_MEAS_LOW;
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end else if (dur_ms > DASH_MAX) begin
                    state_d = ST_DONE;
                    match_d = 1'b0;
                end
            end
            ST_MEAS_LOW: begin
                if (!bus.Start_Sig) begin
                    state_d = ST_IDLE;
                    match_d = 1'b0;
                end else if (rise_c) begin
                    if (dur_ms < GAP_MIN) begin
                        state_d = ST_DONE;
                        match_d = 1'b0;
                    end else begin
                        state_d = ST_MEAS_HIGH;
                    end
                end else if (dur_ms > GAP_MAX) begin
                    state_d = ST_DONE;
                    match_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (!bus.Start_Sig) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_d = (state_d == ST_DONE) && (state_q != ST_DONE);

    assign bus.Done_Sig  = done_q;
    assign bus.Match_Sig = match_q;
    assign bus.Sym_Cnt   = sym_cnt_q;

endmodule

// File: tb/tb_sos_detect_module.sv
// Randomised scenario bench for the SOS receiver against a pulse-list reference model.
module tb_sos_detect_module;

    localparam int T        = 10;
    localparam int DOT_MIN  = 50;
    localparam int DOT_MAX  = 150;
    localparam int DASH_MIN = 250;
    localparam int DASH_MAX = 500;
    localparam int GAP_MIN  = 50;
    localparam int GAP_MAX  = 600;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    int hi_ms[16];
    int lo_ms[16];
    int rise_cyc[16];
    int fall_cyc[16];
    int npulse = 0;
    int done_log[$];
    int exp_cnt, exp_done, exp_match;

    sos_detect_module_if bus ();

    sos_detect_module #(
        .T_MS(T), .DOT_MIN_MS(DOT_MIN), .DOT_MAX_MS(DOT_MAX),
        .DASH_MIN_MS(DASH_MIN), .DASH_MAX_MS(DASH_MAX),
        .GAP_MIN_MS(GAP_MIN), .GAP_MAX_MS(GAP_MAX)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.Done_Sig === 1'b1) done_log.push_back(cyc);

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_stream();
        for (int i = 0; i < npulse; i++) begin
            bus.Pin_In  = 1'b1;
            rise_cyc[i] = cyc;
            wait_cyc(hi_ms[i] * T);
            bus.Pin_In  = 1'b0;
            fall_cyc[i] = cyc;
            wait_cyc(lo_ms[i] * T);
        end
    endtask

    // Random S-O-S: each width lands just inside the lower end of its legal window
    task automatic load_sos(input int spread);
        npulse = 9;
        for (int i = 0; i < 9; i++) begin
            if (i >= 3 && i <= 5) hi_ms[i] = DASH_MIN + 1 + int'($urandom_range(spread - 1));
            else                  hi_ms[i] = DOT_MIN + 1 + int'($urandom_range(spread - 1));
            lo_ms[i] = GAP_MIN + 1 + int'($urandom_range(spread - 1));
        end
    endtask

    // A pulse of H ms reads as H-1 whole ms; a limit L is exceeded once L+1 ms have
    // elapsed, i.e. T*(L+1)+1 cycles after the edge is seen. Done is seen 3 edges after
    // the pin change is driven.
    function automatic void run_model();
        int m, g, cnt;
        bit is_dot, is_dash, ok;
        cnt = 0; exp_match = 0; exp_done = -1;
        for (int i = 0; i < npulse; i++) begin
            m = hi_ms[i] - 1;
            if (m > DASH_MAX) begin exp_done = rise_cyc[i] + 3 + T * (DASH_MAX + 1) + 1; break; end
            is_dot  = (m >= DOT_MIN) && (m <= DOT_MAX);
            is_dash = (m >= DASH_MIN) && (m <= DASH_MAX);
            ok = (cnt >= 3 && cnt <= 5) ? is_dash : is_dot;
            if (!ok) begin exp_done = fall_cyc[i] + 3; break; end
            cnt++;
            if (cnt == 9) begin exp_match = 1; exp_done = fall_cyc[i] + 3; break; end
            g = lo_ms[i] - 1;
            if (g > GAP_MAX) begin exp_done = fall_cyc[i] + 3 + T * (GAP_MAX + 1) + 1; break; end
            if (i + 1 < npulse && g < GAP_MIN) begin exp_done = rise_cyc[i + 1] + 3; break; end
        end
        exp_cnt = cnt;
    endfunction

    task automatic test_reset();
        bus.Start_Sig = 1'b0; bus.Pin_In = 1'b0; rst_n = 1'b0;
        wait_cyc(3);
        total++; if (bus.Done_Sig !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.Done_Sig); end
        total++; if (bus.Match_Sig !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", bus.Match_Sig); end
        total++; if (bus.Sym_Cnt !== 4'd0) begin bad++; $display("FAIL reset_sym got=%0d want=0", bus.Sym_Cnt); end
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_sos_pass();
        done_log.delete();
        load_sos(20);
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL pass_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL pass_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        total++; if (bus.Match_Sig !== 1'(exp_match)) begin bad++; $display("FAIL pass_match got=%b want=%0d", bus.Match_Sig, exp_match); end
        total++; if (bus.Sym_Cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL pass_sym got=%0d want=%0d", bus.Sym_Cnt, exp_cnt); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
    endtask

    task automatic test_wrong_symbol();
        done_log.delete();
        load_sos(20);
        npulse = 5;
        hi_ms[3] = 100;
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL wrong_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL wrong_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        total++; if (bus.Match_Sig !== 1'(exp_match)) begin bad++; $display("FAIL wrong_match got=%b want=%0d", bus.Match_Sig, exp_match); end
        total++; if (bus.Sym_Cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL wrong_sym got=%0d want=%0d", bus.Sym_Cnt, exp_cnt); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
    endtask

    task automatic test_gap_timeout();
        done_log.delete();
        load_sos(20);
        npulse = 2;
        lo_ms[1] = 700;
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL gap_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL gap_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        total++; if (bus.Match_Sig !== 1'(exp_match)) begin bad++; $display("FAIL gap_match got=%b want=%0d", bus.Match_Sig, exp_match); end
        total++; if (bus.Sym_Cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL gap_sym got=%0d want=%0d", bus.Sym_Cnt, exp_cnt); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
    endtask

    task automatic test_bad_width();
        int widths[2];
        widths[0] = 200; widths[1] = 600;
        for (int k = 0; k < 2; k++) begin
            done_log.delete();
            npulse = 1; hi_ms[0] = widths[k]; lo_ms[0] = 10;
            bus.Start_Sig = 1'b1; wait_cyc(2);
            send_stream(); run_model(); wait_cyc(5);
            total++; if (done_log.size() != 1) begin bad++; $display("FAIL width%0d_done_count got=%0d want=1", widths[k], done_log.size()); end
            total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
                $display("FAIL width%0d_done_cycle got=%0d want=%0d", widths[k], done_log.size() == 0 ? -1 : done_log[0], exp_done); end
            total++; if (bus.Match_Sig !== 1'(exp_match)) begin bad++; $display("FAIL width%0d_match got=%b want=%0d", widths[k], bus.Match_Sig, exp_match); end
            total++; if (bus.Sym_Cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL width%0d_sym got=%0d want=%0d", widths[k], bus.Sym_Cnt, exp_cnt); end
            bus.Start_Sig = 1'b0; wait_cyc(3);
        end
    endtask

    task automatic test_boundaries();
        done_log.delete();
        npulse = 3;
        hi_ms[0] = DOT_MAX + 1; lo_ms[0] = GAP_MIN + 1;
        hi_ms[1] = DOT_MIN + 1; lo_ms[1] = GAP_MIN + 1;
        hi_ms[2] = DOT_MAX + 2; lo_ms[2] = 10;
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL edge_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL edge_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        total++; if (bus.Sym_Cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL edge_sym got=%0d want=%0d", bus.Sym_Cnt, exp_cnt); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
    endtask

    task automatic test_abort();
        done_log.delete();
        load_sos(20);
        npulse = 3;
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream();
        bus.Start_Sig = 1'b0; wait_cyc(3);
        total++; if (done_log.size() != 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", done_log.size()); end
        total++; if (bus.Match_Sig !== 1'b0) begin bad++; $display("FAIL abort_match got=%b want=0", bus.Match_Sig); end
        total++; if (bus.Sym_Cnt !== 4'd3) begin bad++; $display("FAIL abort_sym got=%0d want=3", bus.Sym_Cnt); end
        // Reset while a pulse is being measured
        load_sos(20);
        npulse = 2;
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream();
        bus.Pin_In = 1'b1; wait_cyc(300);
        total++; if (bus.Sym_Cnt !== 4'd2) begin bad++; $display("FAIL prerst_sym got=%0d want=2", bus.Sym_Cnt); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.Done_Sig !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.Done_Sig); end
        total++; if (bus.Match_Sig !== 1'b0) begin bad++; $display("FAIL rst_match got=%b want=0", bus.Match_Sig); end
        total++; if (bus.Sym_Cnt !== 4'd0) begin bad++; $display("FAIL rst_sym got=%0d want=0", bus.Sym_Cnt); end
        @(negedge clk);
        rst_n = 1'b1; bus.Start_Sig = 1'b0; bus.Pin_In = 1'b0;
        wait_cyc(20);
        total++; if (done_log.size() != 0) begin bad++; $display("FAIL rst_done_count got=%0d want=0", done_log.size()); end
    endtask

    task automatic test_back_to_back();
        done_log.delete();
        load_sos(5);
        bus.Start_Sig = 1'b1; wait_cyc(2);
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL b2b_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        total++; if (bus.Match_Sig !== 1'b1) begin bad++; $display("FAIL b2b_match got=%b want=1", bus.Match_Sig); end
        // Second S-O-S with Start_Sig still high must be ignored
        done_log.delete();
        load_sos(5);
        send_stream(); wait_cyc(5);
        total++; if (done_log.size() != 0) begin bad++; $display("FAIL rearm_done_count got=%0d want=0", done_log.size()); end
        total++; if (bus.Sym_Cnt !== 4'd9) begin bad++; $display("FAIL rearm_sym got=%0d want=9", bus.Sym_Cnt); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
        total++; if (bus.Match_Sig !== 1'b1) begin bad++; $display("FAIL hold_match got=%b want=1", bus.Match_Sig); end
        bus.Start_Sig = 1'b1; wait_cyc(2);
        total++; if (bus.Match_Sig !== 1'b0) begin bad++; $display("FAIL restart_match got=%b want=0", bus.Match_Sig); end
        total++; if (bus.Sym_Cnt !== 4'd0) begin bad++; $display("FAIL restart_sym got=%0d want=0", bus.Sym_Cnt); end
        npulse = 1; hi_ms[0] = 30; lo_ms[0] = 10;
        send_stream(); run_model(); wait_cyc(5);
        total++; if (done_log.size() != 1) begin bad++; $display("FAIL new_done_count got=%0d want=1", done_log.size()); end
        total++; if (done_log.size() == 0 || done_log[0] != exp_done) begin bad++;
            $display("FAIL new_done_cycle got=%0d want=%0d", done_log.size() == 0 ? -1 : done_log[0], exp_done); end
        bus.Start_Sig = 1'b0; wait_cyc(3);
    endtask

    initial begin
        bus.Start_Sig = 1'b0;
        bus.Pin_In    = 1'b0;
        @(negedge clk);
        test_reset();
        test_sos_pass();
        test_wrong_symbol();
        test_gap_timeout();
        test_bad_width();
        test_boundaries();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sos_detect_module.md
Name: sos_detect_module

Overview:
Receive-side counterpart of the SOS Morse generator. It samples a single Morse pin, measures high-pulse and low-gap durations in millisecond ticks, and classifies each pulse as dot or dash. It checks that the 9-symbol sequence S-O-S (dot×3, dash×3, dot×3) arrives within timing limits. It is controlled by the same Start_Sig/Done_Sig level-handshake used by the codebase's control modules, and reports the result on Match_Sig.

Parameters:
T_MS, 50000, CLK cycles per 1 ms tick (50 MHz).
DOT_MIN_MS, 50, minimum dot high time in ms.
DOT_MAX_MS, 150, maximum dot high time in ms.
DASH_MIN_MS, 250, minimum dash high time in ms.
DASH_MAX_MS, 500, maximum dash high time in ms.
GAP_MIN_MS, 50, minimum low gap between symbols in ms.
GAP_MAX_MS, 600, maximum low gap between symbols in ms.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RSTn  input  1  synchronous active-low reset, sampled on rising CLK.
Start_Sig  input  1  level request; held high by the controller until Done_Sig is seen.
Pin_In  input  1  asynchronous Morse line; high = tone on, idle low.
Done_Sig  output  1  one-cycle pulse when detection ends (pass or fail).
Match_Sig  output  1  1 = valid SOS received; valid with Done_Sig, held until next start.
Sym_Cnt  output  4  symbols accepted so far (0..9), for debug and LEDs.

Behaviour:
- Reset: RSTn low at a rising edge clears everything: state IDLE, Done_Sig=0, Match_Sig=0, Sym_Cnt=0, sync flops=0, counters=0. Reset mid-operation aborts immediately and produces no Done_Sig.
- Input path: 2-flop synchronizer (s1, s2) plus a history flop s3. rise = s2 & ~s3; fall = ~s2 & s3.
- ms prescaler: counts 0..T_MS-1 and emits tick at T_MS-1. It restarts from 0 on every rise or fall. Duration counter dur_ms (10 bits) increments on tick, clears on each edge, and saturates at 1023.
- FSM states:
  - IDLE: Start_Sig=1 -> WAIT_HIGH. Also clears Sym_Cnt and Match_Sig.
  - WAIT_HIGH: waits for the first rise with no timeout. rise -> MEAS_HIGH.
  - MEAS_HIGH: on fall, classify dur_ms. Dot if DOT_MIN_MS ≤ dur_ms ≤ DOT_MAX_MS. Dash if DASH_MIN_MS ≤ dur_ms ≤ DASH_MAX_MS. Anything else is bad.
    - Expected symbol: dash for Sym_Cnt 3..5, dot otherwise.
    - Match and Sym_Cnt=8: Sym_Cnt becomes 9, Match_Sig=1 -> DONE.
    - Match otherwise: Sym_Cnt increments -> MEAS_LOW.
    - Bad or mismatch: Match_Sig=0 -> DONE.
    - dur_ms > DASH_MAX_MS while the pin is still high: fail immediately -> DONE.
  - MEAS_LOW: on rise, if dur_ms < GAP_MIN_MS, fail -> DONE; else -> MEAS_HIGH. dur_ms > GAP_MAX_MS: fail -> DONE.
  - DONE: Done_Sig=1 for exactly the one cycle of entry into DONE. Stays in DONE until Start_Sig=0, then -> IDLE. No re-arm while Start_Sig is still high.
- Start_Sig dropping in WAIT_HIGH, MEAS_HIGH or MEAS_LOW: return to IDLE next cycle with no Done_Sig. Match_Sig=0 and Sym_Cnt keeps its value.
- Latency: count the edge that first samples Pin_In low after the 9th pulse as edge 1. Done_Sig is high after edge 3.
- Simultaneous events: a tick in the same cycle as an edge is discarded (the edge clear wins). A timeout in the same cycle as a fall: the fall classification wins.
- Extra pulses after the 9th symbol are ignored, because the block is already in DONE.

Decomposition:
- Shared header sos_defs.vh holds:
  - state encodings: IDLE, WAIT_HIGH, MEAS_HIGH, MEAS_LOW, DONE;
  - symbol codes: SYM_DOT, SYM_DASH, SYM_BAD;
  - SOS pattern constant 9'b000_111_000 (1 = dash, index 0 = first symbol);
  - default timing values, shared with the generator.
- One sub-module, pulse_meter_module: synchronizer, edge detect, ms prescaler and dur_ms counter. It outputs rise, fall and dur_ms.
- The FSM, classification and pattern check stay in the top.

Test Plan:
Use T_MS=10 in simulation (1 ms = 10 CLK).
1. Start_Sig=1; send dots 100 ms, dashes 300 ms, gaps 100 ms in S-O-S order -> single Done_Sig pulse, Match_Sig=1, Sym_Cnt=9, Done_Sig high after edge 3 following the last fall.
2. Same stream but the 4th pulse is 100 ms (a dot where a dash is expected) -> Done_Sig at that fall, Match_Sig=0, Sym_Cnt=3.
3. After the 2nd dot, hold the line low for 700 ms -> Done_Sig when dur_ms reaches 601, Match_Sig=0, Sym_Cnt=2.
4. First pulse 200 ms (between the dot and dash windows) -> fail at the fall, Match_Sig=0, Sym_Cnt=0. Separately, a 600 ms high pulse -> fail at dur_ms=501 while the pin is still high.
5. Drop Start_Sig mid-sequence -> IDLE with no Done_Sig. Then assert RSTn=0 for 1 cycle in MEAS_HIGH -> all outputs 0 on the next edge.
6. Hold Start_Sig high after a passing Done_Sig and send another SOS -> no second Done_Sig. Lower then raise Start_Sig -> Match_Sig and Sym_Cnt clear and a new detection runs.
